// File: rtl/bram_lane_clr.sv
// bram_lane_clr: simple-dual-port block RAM for NTT coefficient storage.
// Each word packs LANES coefficients, and each lane can be written on its own.
// Addresses are registered, so read data appears one cycle after the address.
// A clear engine zeroes the whole array after reset (CLEAR_ON_RESET=1)
// or when clr_start is pulsed.
// Optional macro BRAM_LANE_CLR_OUTREG_EN adds an output register stage
// on both data outputs. That stage uses an async reset to 0 and raises the
// read latency to 2 cycles.
module bram_lane_clr #(
  parameter int WIDTH          = 36,
  parameter int ADDR_W         = 12,
  parameter int LANES          = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              wr_en,
  input  logic [LANES-1:0]  wr_lane,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_din,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  wr_dout,
  output logic [WIDTH-1:0]  rd_dout
);

  localparam int LW    = WIDTH / LANES;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wra_q, rda_q;
  logic [WIDTH-1:0]  ram [DEPTH];

  // State, clear counter and both address registers; addresses track every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      wra_q   <= '0;
      rda_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wra_q   <= wr_addr;
      rda_q   <= rd_addr;
    end
  end

  // Clear engine: sweep every word once, then return to IDLE; clr_start mid-sweep is ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Array write port: the clear sweep owns the port while busy; otherwise lane-masked writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        ram[cnt_q] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < LANES; k++) begin
          if (wr_lane[k]) begin
            ram[wr_addr][k*LW +: LW] <= wr_din[k*LW +: LW];
          end
        end
      end
    end
  end

  assign clr_busy = (state_q == CLEAR);

`ifdef BRAM_LANE_CLR_OUTREG_EN
  logic [WIDTH-1:0] wr_dout_q, rd_dout_q;

  // Output stage: re-time both read ports, giving a two-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_dout_q <= '0;
      rd_dout_q <= '0;
    end else begin
      wr_dout_q <= ram[wra_q];
      rd_dout_q <= ram[rda_q];
    end
  end

  assign wr_dout = wr_dout_q;
  assign rd_dout = rd_dout_q;
`else
  assign wr_dout = ram[wra_q];
  assign rd_dout = ram[rda_q];
`endif

endmodule

// File: tb/tb_bram_lane_clr.sv
// tb_bram_lane_clr: checks bram_lane_clr (ADDR_W=4) against a word-level memory model,
// plus directed scenarios with literal expectations.
module tb_bram_lane_clr;

  localparam int WIDTH  = 36;
  localparam int ADDR_W = 4;
  localparam int LANES  = 3;
  localparam int DEPTH  = 16;
  localparam int LW     = 12;
`ifdef BRAM_LANE_CLR_OUTREG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr_start = 1'b0;
  logic              clr_busy;
  logic              wr_en = 1'b0;
  logic [LANES-1:0]  wr_lane = '0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_din = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [WIDTH-1:0]  wr_dout;
  logic [WIDTH-1:0]  rd_dout;

  int errors = 0;
  int checks = 0;

  bram_lane_clr #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .LANES(LANES), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr), .wr_din(wr_din),
    .rd_addr(rd_addr), .wr_dout(wr_dout), .rd_dout(rd_dout)
  );

  always #5 clk = ~clk;

  // Reference model state: memory image, per-word "contents known" flag, remaining clear work
  logic [WIDTH-1:0] mem [DEPTH];
  bit               known [DEPTH];
  int               clrLeft = 0;
  int               clrAddr = 0;
  bit               started = 1'b0;
  logic [WIDTH-1:0] p1Rd, p1Wr, expRd, expWr;
  bit               p1RdK, p1WrK, expRdK, expWrK;
  bit               expBusy;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      known[i] = 1'b0;
      mem[i]   = '0;
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [LANES-1:0] lane,
                               input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] din,
                               input logic [ADDR_W-1:0] ra, input logic cs);
    wr_en     = we;
    wr_lane   = lane;
    wr_addr   = wa;
    wr_din    = din;
    rd_addr   = ra;
    clr_start = cs;
    @(posedge clk);
    #2;
  endtask

  task automatic settle(input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra);
    if (OUTREG) applyStimulus(1'b0, '0, wa, '0, ra, 1'b0);
  endtask

  // Model update at each rising edge: a pending clear consumes the port, else a masked write
  always @(posedge clk) begin
    if (rst) begin
      clrLeft = DEPTH;
      clrAddr = 0;
      if (OUTREG) begin
        expRd = '0; expWr = '0; expRdK = 1'b1; expWrK = 1'b1;
      end
      p1Rd = mem[0]; p1RdK = known[0];
      p1Wr = mem[0]; p1WrK = known[0];
      started = 1'b1;
    end else begin
      if (clrLeft > 0) begin
        mem[clrAddr]   = '0;
        known[clrAddr] = 1'b1;
        clrAddr        = (clrAddr + 1) % DEPTH;
        clrLeft        = clrLeft - 1;
      end else begin
        if (wr_en) begin
          for (int k = 0; k < LANES; k++)
            if (wr_lane[k]) mem[wr_addr][k*LW +: LW] = wr_din[k*LW +: LW];
          if (wr_lane == 3'b111) known[wr_addr] = 1'b1;
        end
        if (clr_start) begin
          clrLeft = DEPTH;
          clrAddr = 0;
        end
      end
      if (OUTREG) begin
        expRd = p1Rd; expRdK = p1RdK;
        expWr = p1Wr; expWrK = p1WrK;
      end
      p1Rd = mem[rd_addr]; p1RdK = known[rd_addr];
      p1Wr = mem[wr_addr]; p1WrK = known[wr_addr];
    end
    if (!OUTREG) begin
      expRd = p1Rd; expRdK = p1RdK;
      expWr = p1Wr; expWrK = p1WrK;
    end
    expBusy = (clrLeft > 0);
  end

  // Compare process: every falling edge outside reset, outputs against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      checkOutput("clr_busy", WIDTH'(clr_busy), WIDTH'(expBusy));
      if (expRdK) checkOutput("rd_dout", rd_dout, expRd);
      if (expWrK) checkOutput("wr_dout", wr_dout, expWr);
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int n;
    logic [63:0] r64;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Clear after reset, with a write to addr 3 attempted once word 3 is already zeroed
    n = 0;
    while (clr_busy && n < 40) begin
      if (n == 5) applyStimulus(1'b1, 3'b111, 4'd3, 36'hABCDEF012, 4'd0, 1'b0);
      else        applyStimulus(1'b0, 3'b000, 4'd0, '0, 4'd0, 1'b0);
      n++;
    end
    checkOutput("reset_clear_cycles", WIDTH'(n), WIDTH'(16));

    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 3'b000, 4'(a), '0, 4'(a), 1'b0);
      settle(4'(a), 4'(a));
      checkOutput("cleared_word", rd_dout, 36'h0);
    end

    // Lane mask merge
    applyStimulus(1'b1, 3'b111, 4'd5, 36'h111222333, 4'd5, 1'b0);
    applyStimulus(1'b1, 3'b010, 4'd5, 36'hAAABBBCCC, 4'd5, 1'b0);
    settle(4'd5, 4'd5);
    checkOutput("lane_mask_rd", rd_dout, 36'h111BBB333);
    checkOutput("lane_mask_wr", wr_dout, 36'h111BBB333);
    applyStimulus(1'b1, 3'b000, 4'd5, 36'hFFFFFFFFF, 4'd5, 1'b0);
    settle(4'd5, 4'd5);
    checkOutput("empty_mask", rd_dout, 36'h111BBB333);

    // Same-address collision returns new data
    applyStimulus(1'b1, 3'b111, 4'd7, 36'h000000042, 4'd7, 1'b0);
    settle(4'd7, 4'd7);
    checkOutput("collision_rd", rd_dout, 36'h000000042);
    checkOutput("collision_wr", wr_dout, 36'h000000042);

    // Reset in the middle of a clear restarts a full sweep
    applyStimulus(1'b0, 3'b000, 4'd0, '0, 4'd0, 1'b1);
    repeat (8) applyStimulus(1'b0, 3'b000, 4'd0, '0, 4'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    n = 0;
    while (clr_busy && n < 40) begin
      applyStimulus(1'b0, 3'b000, 4'd0, '0, 4'd0, 1'b0);
      n++;
    end
    checkOutput("midclear_reset_cycles", WIDTH'(n), WIDTH'(16));

    // clr_start during a clear neither restarts nor extends it
    applyStimulus(1'b0, 3'b000, 4'd0, '0, 4'd0, 1'b1);
    n = 0;
    while (clr_busy && n < 40) begin
      applyStimulus(1'b0, 3'b000, 4'd0, '0, 4'd0, (n == 10));
      n++;
    end
    checkOutput("restart_ignored_cycles", WIDTH'(n), WIDTH'(16));

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(249, 0) == 0) begin
        wr_en = 1'b0;
        clr_start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
      end else begin
        r64 = {$urandom, $urandom};
        applyStimulus(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                      4'($urandom_range(15, 0)), r64[35:0],
                      4'($urandom_range(15, 0)), ($urandom_range(79, 0) == 0));
      end
    end
    applyStimulus(1'b0, 3'b000, 4'd0, '0, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
